ldpc_3gpp_dec_mem_state_mbank: RTL and testbench
================================================

Name: ldpc_3gpp_dec_mem_state_mbank

Overview:
- Next-generation node-history state memory for the 3GPP LDPC decoder.
- Generalises the single-mode state RAM:
  - run-time address mode: vnode column walk or cnode linear walk.
  - parametrised address and RAM pipeline depth.
  - address-overrun error flag.
- Sits between the node engines and the decoder control; stores pROW_BY_CYCLE x pCOL_BY_CYCLE x pLLR_BY_CYCLE states per word.

Parameters:
pADDR_W        8   RAM address width; depth = 2^pADDR_W words
pSTATE_W       5   bits per node state
pROW_BY_CYCLE  8   rows per word
pCOL_BY_CYCLE  26  columns per word
pLLR_BY_CYCLE  1   LLRs per row/column cell
pADDR_PIPE     2   address-generator register stages, legal 1..2
pRAM_PIPE      1   extra RAM output register, legal 0..1
(Word width W = pROW_BY_CYCLE*pCOL_BY_CYCLE*pLLR_BY_CYCLE*pSTATE_W)

Ports:
iclk      in   1        clock
ireset    in   1        synchronous active-high reset
iclkena   in   1        clock enable; low freezes all state
iused_zc  in   hb_zc_t  lifting size in use, stable for a whole frame
imode     in   1        0 = vnode walk, 1 = cnode walk; sampled on sof
iwrite    in   1        write request
iwstrb    in   strb_t   write strobes (sof/sop/eop/eof)
iwstate   in   W        write data
iread     in   1        read request
irstrb    in   strb_t   read strobes
orval     out  1        read data valid
orstrb    out  strb_t   strobes aligned to orstate
orstate   out  W        read data
oerr      out  1        sticky address-overrun flag

Behaviour:
Reset and enable:
- Synchronous active-high reset on iclk; all logic is gated by iclkena.
- Reset values: orval=0, orstrb=0, oerr=0, counters=0, valid pipes=0. orstate is undefined after reset.
- RAM contents are not cleared by reset.
- Reset mid-frame drops all in-flight reads; no orval is produced for them. The next sof restarts addressing.

Address generators (independent write and read copies), on each accepted iwrite/iread:
- sof&sop: row=0, zc=0, mode latched from imode.
- vnode mode:
  - sop only: row=0, zc=zc+1.
  - otherwise: row=row+iused_zc.
- cnode mode: sop is ignored; row=row+1 each access; zc held 0.
- Address = row+zc, truncated modulo 2^pADDR_W.
- Overrun: if row+zc >= 2^pADDR_W before truncation, oerr is set and held until reset. Data is still written/read at the wrapped address.

Write path:
- Write data and write enable are delayed pADDR_PIPE cycles, then written to the RAM.
- Write latency is pADDR_PIPE+1 cycles from iwrite to visible in RAM.

Read path:
- orval/orstrb are the iread/irstrb delayed by pADDR_PIPE+1+pRAM_PIPE cycles (default 4).
- orval is never asserted without a prior iread.

Collisions and ordering:
- Read and write to the same RAM address in the same RAM cycle: read returns OLD data (read-first), unless the macro below is set.
- Simultaneous sof on read and write is legal; the two generators are independent.
- iwrite and iread may be asserted together every cycle; throughput is one word per cycle per port.

Optional Feature:
LDPC_3GPP_DEC_MEM_STATE_BYPASS_EN
- Defined: on a same-address same-cycle collision at the RAM stage, the new write data is forwarded to the read output. Read latency is unchanged.
- Not defined: read-first behaviour with no forwarding logic.

Test Plan:
- Reset, then idle 10 cycles -> orval=0, oerr=0 throughout; iclkena=0 during a read burst -> pipeline frozen, then resumes with same latency.
- vnode, iused_zc=4, 3 rows x 4 sop-groups written with data=address, then read back -> orval exactly 4 cycles after each iread; data order matches addresses 0,4,8,1,5,9,2,6,10,3,7,11.
- cnode, 16 consecutive writes then 16 reads -> addresses 0..15 linear; orstate equals written pattern; sop mid-frame does not reset row.
- Overrun, pADDR_W=4, cnode, 18 writes -> oerr rises on the write to address 16, stays 1; address 16 wraps to 0 and overwrites word 0.
- Collision: write 0xA5-pattern to address 3 while reading address 3 in the same RAM cycle -> old data without the macro, new data with LDPC_3GPP_DEC_MEM_STATE_BYPASS_EN.
- ireset asserted 2 cycles after a 4-read burst starts -> no orval for the dropped reads; a new frame after reset reads correctly from address 0.

Source files
------------

// File: rtl/ldpc_3gpp_dec_mem_state_mbank.sv
// Node-history state memory for the 3GPP LDPC decoder: independent write/read address generators
// (vnode column walk or cnode linear walk), pipelined RAM and a sticky address-overrun flag.
// Strobe layout: [0]=sof [1]=sop [2]=eop [3]=eof. iused_zc is a 9-bit lifting size.
// Define LDPC_3GPP_DEC_MEM_STATE_BYPASS_EN to forward same-address write data to the read port.
module ldpc_3gpp_dec_mem_state_mbank #(
  parameter int pADDR_W       = 8,
  parameter int pSTATE_W      = 5,
  parameter int pROW_BY_CYCLE = 8,
  parameter int pCOL_BY_CYCLE = 26,
  parameter int pLLR_BY_CYCLE = 1,
  parameter int pADDR_PIPE    = 2,
  parameter int pRAM_PIPE     = 1,
  localparam int W = pROW_BY_CYCLE * pCOL_BY_CYCLE * pLLR_BY_CYCLE * pSTATE_W
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         iclkena,
  input  logic [8:0]   iused_zc,
  input  logic         imode,
  input  logic         iwrite,
  input  logic [3:0]   iwstrb,
  input  logic [W-1:0] iwstate,
  input  logic         iread,
  input  logic [3:0]   irstrb,
  output logic         orval,
  output logic [3:0]   orstrb,
  output logic [W-1:0] orstate,
  output logic         oerr
);

  localparam int DEPTH  = 1 << pADDR_W;
  // Counters are one bit wider than the larger of address and zc so the first overrun is never masked by wrap.
  localparam int CNT_W  = ((pADDR_W > 9) ? pADDR_W : 9) + 1;
  localparam int RD_LAT = pADDR_PIPE + 1 + pRAM_PIPE;

  // Generator index 0 serves the write port, index 1 the read port.
  logic [1:0]       req;
  logic [1:0]       sof;
  logic [1:0]       sop;
  logic [1:0]       mode;
  logic [1:0]       mode_nxt;
  logic [1:0]       ovr;
  logic [CNT_W-1:0] row     [2];
  logic [CNT_W-1:0] zc      [2];
  logic [CNT_W-1:0] row_nxt [2];
  logic [CNT_W-1:0] zc_nxt  [2];
  logic [CNT_W:0]   sum     [2];
  logic             unused_strb;

  assign req = {iread, iwrite};
  assign sof = {irstrb[0], iwstrb[0]};
  assign sop = {irstrb[1], iwstrb[1]};
  assign unused_strb = ^iwstrb[3:2];

  // NOTE: combinational logic uses blocking '=' with a default first, so every path assigns and no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      row_nxt[p]  = row[p];
      zc_nxt[p]   = zc[p];
      mode_nxt[p] = mode[p];
      if (sof[p] && sop[p]) begin
        row_nxt[p]  = '0;
        zc_nxt[p]   = '0;
        mode_nxt[p] = imode;
      end else if (mode[p]) begin
        row_nxt[p] = row[p] + CNT_W'(1);
        zc_nxt[p]  = '0;
      end else if (sop[p]) begin
        row_nxt[p] = '0;
        zc_nxt[p]  = zc[p] + CNT_W'(1);
      end else begin
        row_nxt[p] = row[p] + CNT_W'(iused_zc);
      end
      sum[p] = {1'b0, row_nxt[p]} + {1'b0, zc_nxt[p]};
      ovr[p] = req[p] && (sum[p] >= (CNT_W + 1)'(DEPTH));
    end
  end

  // Control state: counters, mode, error flag and valid/strobe pipes.
  logic [pADDR_PIPE-1:0]   wen_pipe;
  logic [RD_LAT-1:0]       rval_pipe;
  logic [RD_LAT-1:0][3:0]  rstrb_pipe;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int p = 0; p < 2; p++) begin
        row[p] <= '0;
        zc[p]  <= '0;
      end
      mode       <= '0;
      oerr       <= 1'b0;
      wen_pipe   <= '0;
      rval_pipe  <= '0;
      rstrb_pipe <= '0;
    end else if (iclkena) begin
      for (int p = 0; p < 2; p++) begin
        if (req[p]) begin
          row[p]  <= row_nxt[p];
          zc[p]   <= zc_nxt[p];
          mode[p] <= mode_nxt[p];
        end
      end
      if (|ovr) oerr <= 1'b1;
      wen_pipe   <= pADDR_PIPE'({wen_pipe, iwrite});
      rval_pipe  <= RD_LAT'({rval_pipe, iread});
      rstrb_pipe <= (RD_LAT * 4)'({rstrb_pipe, irstrb});
    end
  end

  // Address and write-data pipes carry no reset; the valid pipes qualify them.
  logic [pADDR_PIPE-1:0][pADDR_W-1:0] waddr_pipe;
  logic [pADDR_PIPE-1:0][pADDR_W-1:0] raddr_pipe;
  logic [pADDR_PIPE-1:0][W-1:0]       wdata_pipe;

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      waddr_pipe <= (pADDR_PIPE * pADDR_W)'({waddr_pipe, sum[0][pADDR_W-1:0]});
      raddr_pipe <= (pADDR_PIPE * pADDR_W)'({raddr_pipe, sum[1][pADDR_W-1:0]});
      wdata_pipe <= (pADDR_PIPE * W)'({wdata_pipe, iwstate});
    end
  end

  logic               ram_we;
  logic               ram_re;
  logic [pADDR_W-1:0] ram_waddr;
  logic [pADDR_W-1:0] ram_raddr;
  logic [W-1:0]       ram_wdata;
  logic [W-1:0]       ram_q;
  logic [W-1:0]       mem [DEPTH];

  assign ram_we    = wen_pipe[pADDR_PIPE-1];
  assign ram_re    = rval_pipe[pADDR_PIPE-1];
  assign ram_waddr = waddr_pipe[pADDR_PIPE-1];
  assign ram_raddr = raddr_pipe[pADDR_PIPE-1];
  assign ram_wdata = wdata_pipe[pADDR_PIPE-1];

  // NOTE: the RAM array and its output register have no reset so the array maps onto block RAM.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      if (ram_re) begin
`ifdef LDPC_3GPP_DEC_MEM_STATE_BYPASS_EN
        if (ram_we && (ram_waddr == ram_raddr)) ram_q <= ram_wdata;
        else                                    ram_q <= mem[ram_raddr];
`else
        ram_q <= mem[ram_raddr];
`endif
      end
    end
  end

  generate
    if (pRAM_PIPE != 0) begin : g_out_reg
      logic [W-1:0] out_q;
      always_ff @(posedge iclk) begin
        if (iclkena && rval_pipe[pADDR_PIPE]) out_q <= ram_q;
      end
      assign orstate = out_q;
    end else begin : g_no_out_reg
      assign orstate = ram_q;
    end
  endgenerate

  assign orval  = rval_pipe[RD_LAT-1];
  assign orstrb = rstrb_pipe[RD_LAT-1];

endmodule

// File: tb/tb_ldpc_3gpp_dec_mem_state_mbank.sv
// Directed bench for ldpc_3gpp_dec_mem_state_mbank: 16-word RAM, 16-bit words, read latency 4.
module tb_ldpc_3gpp_dec_mem_state_mbank;

  localparam int W      = 16;
  localparam int RD_LAT = 4;

  logic         iclk = 1'b0;
  logic         ireset, iclkena, imode, iwrite, iread;
  logic [8:0]   iused_zc;
  logic [3:0]   iwstrb, irstrb;
  logic [W-1:0] iwstate;
  logic         orval, oerr;
  logic [3:0]   orstrb;
  logic [W-1:0] orstate;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0]   st_strb  [32];
  logic [W-1:0] st_data  [32];
  logic         cap_val  [40];
  logic [W-1:0] cap_data [40];
  logic [3:0]   cap_strb [40];
  logic         cap_err  [40];

  ldpc_3gpp_dec_mem_state_mbank #(
    .pADDR_W(4), .pSTATE_W(4), .pROW_BY_CYCLE(2), .pCOL_BY_CYCLE(2),
    .pLLR_BY_CYCLE(1), .pADDR_PIPE(2), .pRAM_PIPE(1)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_zc(iused_zc),
    .imode(imode), .iwrite(iwrite), .iwstrb(iwstrb), .iwstate(iwstate),
    .iread(iread), .irstrb(irstrb), .orval(orval), .orstrb(orstrb),
    .orstate(orstate), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  // Drives n accesses on the selected port(s) from st_strb/st_data and captures outputs for n+RD_LAT cycles.
  task automatic run_burst(input int n, input bit wr, input bit rd, input logic mode);
    for (int c = 0; c < n + RD_LAT; c++) begin
      imode   = mode;
      iwrite  = wr && (c < n);
      iread   = rd && (c < n);
      iwstrb  = (wr && c < n) ? st_strb[c] : 4'b0000;
      irstrb  = (rd && c < n) ? st_strb[c] : 4'b0000;
      iwstate = (c < n) ? st_data[c] : '0;
      tick();
      cap_val[c]  = orval;
      cap_data[c] = orstate;
      cap_strb[c] = orstrb;
      cap_err[c]  = oerr;
    end
    iwrite = 1'b0;
    iread  = 1'b0;
    iwstrb = '0;
    irstrb = '0;
  endtask

  task automatic test_reset;
    ireset = 1'b1;
    repeat (3) tick();
    ireset = 1'b0;
    tests_run++;
    if (orval !== 1'b0) begin tests_failed++; $display("FAIL reset_orval: got %b want 0", orval); end
    tests_run++;
    if (oerr !== 1'b0) begin tests_failed++; $display("FAIL reset_oerr: got %b want 0", oerr); end
    tests_run++;
    if (orstrb !== 4'b0000) begin tests_failed++; $display("FAIL reset_orstrb: got %b want 0000", orstrb); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (orval !== 1'b0 || oerr !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle[%0d]: got orval=%b oerr=%b want 0 0", i, orval, oerr);
      end
    end
  endtask

  task automatic test_vnode;
    int addr_seq [12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    logic exp_v;
    iused_zc = 9'd4;
    for (int i = 0; i < 12; i++) begin
      st_strb[i] = (i == 0) ? 4'b0011 : (i % 3 == 0) ? 4'b0010 :
                   (i == 11) ? 4'b1100 : (i % 3 == 2) ? 4'b0100 : 4'b0000;
      st_data[i] = 16'hD000 | 16'(addr_seq[i]);
    end
    run_burst(12, 1'b1, 1'b0, 1'b0);
    run_burst(12, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 12 + RD_LAT; c++) begin
      exp_v = (c >= 3) && (c < 15);
      tests_run++;
      if (cap_val[c] !== exp_v) begin
        tests_failed++;
        $display("FAIL vnode_orval[%0d]: got %b want %b", c, cap_val[c], exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (cap_data[c] !== (16'hD000 | 16'(addr_seq[c-3])) || cap_strb[c] !== st_strb[c-3]) begin
          tests_failed++;
          $display("FAIL vnode_data[%0d]: got %h/%b want %h/%b", c, cap_data[c], cap_strb[c],
                   16'hD000 | 16'(addr_seq[c-3]), st_strb[c-3]);
        end
      end
    end
    // Linear read-back exposes where each vnode write actually landed.
    for (int i = 0; i < 12; i++) st_strb[i] = (i == 0) ? 4'b0011 : (i == 11) ? 4'b1100 : 4'b0000;
    run_burst(12, 1'b0, 1'b1, 1'b1);
    for (int c = 3; c < 15; c++) begin
      tests_run++;
      if (cap_val[c] !== 1'b1 || cap_data[c] !== (16'hD000 | 16'(c - 3))) begin
        tests_failed++;
        $display("FAIL vnode_linear[%0d]: got %b/%h want 1/%h", c - 3, cap_val[c], cap_data[c],
                 16'hD000 | 16'(c - 3));
      end
    end
  endtask

  task automatic test_cnode;
    logic exp_v;
    for (int i = 0; i < 16; i++) begin
      st_strb[i] = (i == 0) ? 4'b0011 : (i == 8) ? 4'b0010 : (i == 15) ? 4'b1100 : 4'b0000;
      st_data[i] = 16'h5A00 + 16'(i);
    end
    run_burst(16, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      st_strb[i] = (i == 0) ? 4'b0011 : (i == 5) ? 4'b0010 : (i == 15) ? 4'b1100 : 4'b0000;
    run_burst(16, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 16 + RD_LAT; c++) begin
      exp_v = (c >= 3) && (c < 19);
      tests_run++;
      if (cap_val[c] !== exp_v) begin
        tests_failed++;
        $display("FAIL cnode_orval[%0d]: got %b want %b", c, cap_val[c], exp_v);
      end
      if (exp_v) begin
        tests_run++;
        if (cap_data[c] !== 16'h5A00 + 16'(c - 3) || cap_strb[c] !== st_strb[c-3]) begin
          tests_failed++;
          $display("FAIL cnode_data[%0d]: got %h/%b want %h/%b", c - 3, cap_data[c], cap_strb[c],
                   16'h5A00 + 16'(c - 3), st_strb[c-3]);
        end
      end
    end
  endtask

  task automatic test_clkena;
    logic exp_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] exp_d [4] = '{16'h0000, 16'h5A00, 16'h5A01, 16'h0000};
    imode = 1'b1;
    iread = 1'b1; irstrb = 4'b0011;
    tick();
    irstrb = 4'b1100;
    tick();
    iclkena = 1'b0;
    irstrb  = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (orval !== 1'b0) begin tests_failed++; $display("FAIL clkena_frozen[%0d]: got orval=%b want 0", i, orval); end
    end
    iclkena = 1'b1;
    iread   = 1'b0;
    irstrb  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (orval !== exp_v[i] || (exp_v[i] && orstate !== exp_d[i])) begin
        tests_failed++;
        $display("FAIL clkena_resume[%0d]: got %b/%h want %b/%h", i, orval, orstate, exp_v[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_collision;
    logic [W-1:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      st_strb[i] = (i == 0) ? 4'b0011 : (i == 3) ? 4'b1100 : 4'b0000;
      st_data[i] = 16'hA5A0 | 16'(i);
    end
    run_burst(4, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4 + RD_LAT; c++) begin
`ifdef LDPC_3GPP_DEC_MEM_STATE_BYPASS_EN
      exp_d = 16'hA5A0 | 16'(c - 3);
`else
      exp_d = 16'h5A00 + 16'(c - 3);
`endif
      tests_run++;
      if (cap_val[c] !== (c >= 3 && c < 7) || (c >= 3 && c < 7 && cap_data[c] !== exp_d)) begin
        tests_failed++;
        $display("FAIL collision[%0d]: got %b/%h want %b/%h", c, cap_val[c], cap_data[c], (c >= 3 && c < 7), exp_d);
      end
    end
    run_burst(4, 1'b0, 1'b1, 1'b1);
    for (int c = 3; c < 7; c++) begin
      tests_run++;
      if (cap_val[c] !== 1'b1 || cap_data[c] !== (16'hA5A0 | 16'(c - 3))) begin
        tests_failed++;
        $display("FAIL collision_after[%0d]: got %b/%h want 1/%h", c - 3, cap_val[c], cap_data[c], 16'hA5A0 | 16'(c - 3));
      end
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 18; i++) begin
      st_strb[i] = (i == 0) ? 4'b0011 : (i == 17) ? 4'b1100 : 4'b0000;
      st_data[i] = 16'h0E00 + 16'(i);
    end
    run_burst(18, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 18 + RD_LAT; c++) begin
      tests_run++;
      if (cap_err[c] !== (c >= 16)) begin
        tests_failed++;
        $display("FAIL overrun_oerr[%0d]: got %b want %b", c, cap_err[c], (c >= 16));
      end
    end
    st_strb[0] = 4'b0011;
    st_strb[1] = 4'b1100;
    run_burst(2, 1'b0, 1'b1, 1'b1);
    tests_run++;
    if (cap_val[3] !== 1'b1 || cap_data[3] !== 16'h0E10) begin
      tests_failed++; $display("FAIL overrun_wrap0: got %b/%h want 1/0e10", cap_val[3], cap_data[3]);
    end
    tests_run++;
    if (cap_val[4] !== 1'b1 || cap_data[4] !== 16'h0E11) begin
      tests_failed++; $display("FAIL overrun_wrap1: got %b/%h want 1/0e11", cap_val[4], cap_data[4]);
    end
    tests_run++;
    if (cap_err[5] !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", cap_err[5]); end
  endtask

  task automatic test_reset_mid_frame;
    imode  = 1'b1;
    iread  = 1'b1;
    irstrb = 4'b0011;
    tick();
    irstrb = 4'b0000;
    tick();
    ireset = 1'b1;
    repeat (2) tick();
    ireset = 1'b0;
    iread  = 1'b0;
    tests_run++;
    if (oerr !== 1'b0) begin tests_failed++; $display("FAIL midreset_oerr: got %b want 0", oerr); end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (orval !== 1'b0) begin tests_failed++; $display("FAIL midreset_dropped[%0d]: got orval=%b want 0", i, orval); end
    end
    st_strb[0] = 4'b1111;
    run_burst(1, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 1 + RD_LAT; c++) begin
      tests_run++;
      if (cap_val[c] !== (c == 3) || (c == 3 && cap_data[c] !== 16'h0E10)) begin
        tests_failed++;
        $display("FAIL midreset_newframe[%0d]: got %b/%h want %b/0e10", c, cap_val[c], cap_data[c], (c == 3));
      end
    end
  endtask

  initial begin
    ireset   = 1'b1;
    iclkena  = 1'b1;
    imode    = 1'b0;
    iwrite   = 1'b0;
    iread    = 1'b0;
    iwstrb   = '0;
    irstrb   = '0;
    iwstate  = '0;
    iused_zc = 9'd4;
    test_reset();
    test_vnode();
    test_cnode();
    test_clkena();
    test_collision();
    test_overrun();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
